// File: rtl/fp32_add_core.sv
// Multi-cycle IEEE-754 binary32 adder/subtractor: round-to-nearest-even, denormals flushed to zero.
// One result every six cycles: start edge, then UNPACK, ALIGN, ADD, NORM, ROUND.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for start; operands latched on the start edge
//   S_UNPACK | split fields, flush denormals, resolve NaN/Inf specials
//   S_ALIGN  | order by magnitude, right-shift smaller into G/R/S datapath
//   S_ADD    | add or subtract magnitudes (carry kept)
//   S_NORM   | carry shift or leading-zero shift, underflow flush
//   S_ROUND  | nearest-even rounding, overflow, publish result and flags
module fp32_add_core #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    op_sub,
   input  logic [EXP_W+FRAC_W:0]   op_a,
   input  logic [EXP_W+FRAC_W:0]   op_b,
   output logic [EXP_W+FRAC_W:0]   result,
   output logic                    done,
   output logic                    busy,
   output logic                    flag_ovf,
   output logic                    flag_unf,
   output logic                    flag_inv,
   output logic                    flag_inx
);
   localparam int W     = 1 + EXP_W + FRAC_W;
   localparam int SIG_W = FRAC_W + 1;
   localparam int DP_W  = SIG_W + 3;
   localparam int EN_W  = EXP_W + 2;
   localparam int LZ_W  = $clog2(DP_W + 1);
   localparam logic [EXP_W-1:0] EMAX = '1;
   localparam logic [W-1:0]     QNAN = {1'b0, EMAX, 1'b1, {(FRAC_W-1){1'b0}}};

   typedef logic signed [EN_W-1:0] sexp_t;
   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;

   state_t state;

   logic [W-1:0]       a_q, b_q;
   logic               sub_q;
   logic               sa_u, sb_u;
   logic [EXP_W-1:0]   ea_u, eb_u;
   logic [SIG_W-1:0]   ma_u, mb_u;
   logic               spec_q, spec_inv_q;
   logic [W-1:0]       spec_res_q;
   logic               sl_q, ss_q;
   logic [EXP_W-1:0]   el_q;
   logic [DP_W-1:0]    ml_q, ms_q;
   logic [DP_W:0]      sum_q;
   logic [DP_W-1:0]    mn_q;
   sexp_t              en_q;
   logic               sn_q, zero_q, unf_q;

   // unpack
   logic               sa_d, sb_d, a_nan, b_nan, a_inf, b_inf;
   logic [EXP_W-1:0]   ea_d, eb_d;
   logic [SIG_W-1:0]   ma_d, mb_d;
   logic               spec_d, spec_inv_d;
   logic [W-1:0]       spec_res_d;

   always_comb begin
      ea_d = a_q[W-2:FRAC_W];
      eb_d = b_q[W-2:FRAC_W];
      sa_d = a_q[W-1];
      sb_d = b_q[W-1] ^ sub_q;
      ma_d = (ea_d == '0) ? '0 : {1'b1, a_q[FRAC_W-1:0]};
      mb_d = (eb_d == '0) ? '0 : {1'b1, b_q[FRAC_W-1:0]};
      a_nan = (ea_d == EMAX) && (a_q[FRAC_W-1:0] != '0);
      b_nan = (eb_d == EMAX) && (b_q[FRAC_W-1:0] != '0);
      a_inf = (ea_d == EMAX) && (a_q[FRAC_W-1:0] == '0);
      b_inf = (eb_d == EMAX) && (b_q[FRAC_W-1:0] == '0);
      spec_d     = 1'b1;
      spec_inv_d = 1'b0;
      spec_res_d = QNAN;
      if (a_nan || b_nan) begin
         spec_res_d = QNAN;
      end else if (a_inf && b_inf && (sa_d != sb_d)) begin
         spec_inv_d = 1'b1;
      end else if (a_inf) begin
         spec_res_d = {sa_d, EMAX, {FRAC_W{1'b0}}};
      end else if (b_inf) begin
         spec_res_d = {sb_d, EMAX, {FRAC_W{1'b0}}};
      end else begin
         spec_d = 1'b0;
      end
   end

   // align: bits shifted below the datapath collapse into the sticky LSB
   logic               a_ge, sl_d, ss_d;
   logic [EXP_W-1:0]   el_d, es_d, diff;
   logic [SIG_W-1:0]   sig_l, sig_s;
   logic [2*DP_W-1:0]  wide;
   logic [DP_W-1:0]    ml_d, ms_d;

   always_comb begin
      a_ge  = {ea_u, ma_u} >= {eb_u, mb_u};
      sl_d  = a_ge ? sa_u : sb_u;
      ss_d  = a_ge ? sb_u : sa_u;
      el_d  = a_ge ? ea_u : eb_u;
      es_d  = a_ge ? eb_u : ea_u;
      sig_l = a_ge ? ma_u : mb_u;
      sig_s = a_ge ? mb_u : ma_u;
      diff  = el_d - es_d;
      ml_d  = {sig_l, 3'b000};
      wide  = {sig_s, 3'b000, {DP_W{1'b0}}} >> diff;
      if (diff >= EXP_W'(DP_W))
         ms_d = {{(DP_W-1){1'b0}}, |sig_s};
      else
         ms_d = wide[2*DP_W-1:DP_W] | {{(DP_W-1){1'b0}}, |wide[DP_W-1:0]};
   end

   logic [DP_W:0] sum_d;
   always_comb begin
      if (sl_q == ss_q)
         sum_d = {1'b0, ml_q} + {1'b0, ms_q};
      else
         sum_d = {1'b0, ml_q} - {1'b0, ms_q};
   end

   // normalize
   logic [LZ_W-1:0]  lz;
   logic [DP_W-1:0]  mn_d, shifted;
   sexp_t            base, en_sh, en_d;
   logic             sn_d, zero_d, unf_d;

   always_comb begin
      lz = '0;
      for (int i = 0; i < DP_W; i++)
         if (sum_q[i]) lz = LZ_W'(DP_W - 1 - i);
      base    = $signed({2'b00, el_q});
      shifted = sum_q[DP_W-1:0] << lz;
      en_sh   = base - $signed({{(EN_W-LZ_W){1'b0}}, lz});
      mn_d    = '0;
      en_d    = '0;
      sn_d    = sl_q;
      zero_d  = 1'b0;
      unf_d   = 1'b0;
      if (sum_q[DP_W]) begin
         mn_d = {sum_q[DP_W:2], sum_q[1] | sum_q[0]};
         en_d = base + sexp_t'(1);
      end else if (sum_q == '0) begin
         // exact cancellation gives +0; only -0 + -0 keeps the sign
         zero_d = 1'b1;
         sn_d   = sl_q & ss_q;
      end else if (en_sh <= sexp_t'(0)) begin
         zero_d = 1'b1;
         unf_d  = 1'b1;
      end else begin
         mn_d = shifted;
         en_d = en_sh;
      end
   end

   // round to nearest even
   logic              inc, ovf_d, unf_o, inv_d, inx_d;
   logic [SIG_W:0]    mr;
   sexp_t             er;
   logic [FRAC_W-1:0] frac;
   logic [W-1:0]      res_d;

   always_comb begin
      inc   = mn_q[2] & (mn_q[1] | mn_q[0] | mn_q[3]);
      mr    = {1'b0, mn_q[DP_W-1:3]} + {{SIG_W{1'b0}}, inc};
      er    = en_q + $signed({{(EN_W-1){1'b0}}, mr[SIG_W]});
      frac  = mr[SIG_W] ? mr[SIG_W-1:1] : mr[FRAC_W-1:0];
      res_d = {sn_q, er[EXP_W-1:0], frac};
      ovf_d = 1'b0;
      unf_o = 1'b0;
      inv_d = 1'b0;
      inx_d = mn_q[2] | mn_q[1] | mn_q[0];
      if (spec_q) begin
         res_d = spec_res_q;
         inv_d = spec_inv_q;
         inx_d = 1'b0;
      end else if (zero_q) begin
         res_d = {sn_q, {(W-1){1'b0}}};
         unf_o = unf_q;
         inx_d = unf_q;
      end else if (er >= $signed({2'b00, EMAX})) begin
         res_d = {sn_q, EMAX, {FRAC_W{1'b0}}};
         ovf_d = 1'b1;
         inx_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         result   <= '0;
         done     <= 1'b0;
         busy     <= 1'b0;
         flag_ovf <= 1'b0;
         flag_unf <= 1'b0;
         flag_inv <= 1'b0;
         flag_inx <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               a_q   <= op_a;
               b_q   <= op_b;
               sub_q <= op_sub;
               busy  <= 1'b1;
               state <= S_UNPACK;
            end
            S_UNPACK: begin
               sa_u       <= sa_d;
               sb_u       <= sb_d;
               ea_u       <= ea_d;
               eb_u       <= eb_d;
               ma_u       <= ma_d;
               mb_u       <= mb_d;
               spec_q     <= spec_d;
               spec_inv_q <= spec_inv_d;
               spec_res_q <= spec_res_d;
               state      <= S_ALIGN;
            end
            S_ALIGN: begin
               sl_q  <= sl_d;
               ss_q  <= ss_d;
               el_q  <= el_d;
               ml_q  <= ml_d;
               ms_q  <= ms_d;
               state <= S_ADD;
            end
            S_ADD: begin
               sum_q <= sum_d;
               state <= S_NORM;
            end
            S_NORM: begin
               mn_q   <= mn_d;
               en_q   <= en_d;
               sn_q   <= sn_d;
               zero_q <= zero_d;
               unf_q  <= unf_d;
               state  <= S_ROUND;
            end
            S_ROUND: begin
               result   <= res_d;
               flag_ovf <= ovf_d;
               flag_unf <= unf_o;
               flag_inv <= inv_d;
               flag_inx <= inx_d;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/fp32_add_core.md
Name: fp32_add_core

Overview:
- Multi-cycle IEEE-754 binary32 adder/subtractor that sits directly downstream of the AXI4-Lite slave register file in floating_point_adder_ip.
- The register file drives operand A, operand B, the operation select and a one-cycle start pulse. It reads back result, status flags and done/busy.
- Fixed-latency FSM datapath: unpack, align, add, normalize, round. Round-to-nearest-even, denormals flushed to zero.

Parameters:
- EXP_W, 8, exponent width.
- FRAC_W, 23, stored fraction width; operand/result width is 1+EXP_W+FRAC_W = 32.

Ports:
- clock  in  1  system clock (ACLK domain).
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only when busy=0.
- op_sub  in  1  1 = A−B, 0 = A+B; captured with start.
- op_a  in  32  operand A; captured on the start edge.
- op_b  in  32  operand B; captured on the start edge.
- result  out  32  rounded result; held until the next done.
- done  out  1  one-cycle pulse when result and flags update.
- busy  out  1  high while the FSM is not in IDLE.
- flag_ovf  out  1  overflow to ±Inf.
- flag_unf  out  1  nonzero result flushed to zero.
- flag_inv  out  1  invalid operation (NaN result).
- flag_inx  out  1  result inexact.

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-high. All state updates on the rising edge of clock.
- Reset values: state=IDLE; result=0x00000000; done=0; busy=0; all flags=0. Reset mid-operation aborts with no done pulse.
- FSM states: IDLE → UNPACK → ALIGN → ADD → NORM → ROUND → IDLE. Each state lasts exactly one cycle.
- IDLE: on start=1, latch op_a, op_b and op_sub, then go to UNPACK.
- Start while busy=1 is ignored; operand inputs may change freely after capture.
- Latency: if start is sampled at edge k, done=1 and result/flags are valid after edge k+5.
  - busy=1 after edges k+1..k+5 is wrong; busy=1 after edges k through k+4, busy=0 after k+5.
  - done=1 for exactly the cycle after edge k+5.
  - A start in that same cycle is accepted, giving back-to-back throughput of one result per 6 cycles.
- UNPACK:
  - Effective B sign = sign_b XOR op_sub.
  - Exponent field 0 → operand treated as ±0 (denormal flushed).
  - Hidden bit = 1 for normals.
  - Detect NaN, ±Inf and zero.
- ALIGN:
  - Swap so |A| ≥ |B|; compare exponent first, then fraction.
  - Right-shift the smaller significand by the exponent difference into a 27-bit datapath (1 hidden + 23 fraction + guard, round, sticky).
  - Any bit shifted past sticky ORs into sticky. Shift ≥ 27 leaves sticky only.
- ADD:
  - Equal effective signs: add magnitudes, 28-bit result including carry.
  - Otherwise: subtract smaller from larger.
  - Result sign = sign of the larger operand.
- NORM:
  - On carry-out: shift right by 1 (lost bit ORs into sticky), exponent+1.
  - Otherwise: leading-zero count by priority encoder in a single cycle, shift left, subtract from the exponent.
  - Exponent ≤ 0 after normalization → flush to signed zero, flag_unf=1.
- ROUND (nearest-even):
  - Increment when G=1 and (R|S|LSB)=1.
  - Mantissa overflow from rounding → exponent+1.
  - Exponent ≥ 255 → ±Inf (0x7F800000 | sign), flag_ovf=1, flag_inx=1.
  - flag_inx = G|R|S, or overflow/underflow.
- Special cases (override the datapath result, still full latency):
  - Any NaN input → 0x7FC00000, flag_inv=0 unless inf−inf.
  - Inf + (−Inf) → 0x7FC00000, flag_inv=1.
  - Inf ± finite → that Inf.
- Exact zero from cancellation → +0 (0x00000000). (−0)+(−0) → 0x80000000.
- Flags are replaced, not accumulated, on each done.

Test Plan:
- Basic add: op_a=0x3F800000, op_b=0x40000000, op_sub=0, start at edge k → done after edge k+5, result=0x40400000, all flags 0.
- Cancellation: 0x3F800000 − 0x3F800000 → result 0x00000000, flags 0. Then 0x40400000 − 0x3F800000 → 0x40000000.
- Rounding ties:
  - 0x3F800000 + 0x33800000 → 0x3F800000, flag_inx=1 (tie to even).
  - 0x3F800001 + 0x33800000 → 0x3F800002, flag_inx=1.
- Overflow and specials:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flag_ovf=1, flag_inx=1.
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, flag_inv=1.
  - 0x00000001 + 0x00000000 → 0x00000000.
- Handshake:
  - start again at cycles k+2 and k+3 → ignored, single done.
  - start during the done cycle → accepted, second done 6 cycles after the first.
- Reset mid-operation: assert reset for 1 cycle at k+3 → no done, result=0, busy=0 next cycle; a subsequent start completes normally.
